pim_chunk_engine: RTL and testbench

- Responder side of the PIM chunk handshake: the compute unit that the PIM controller drives once per sub-chunk.
- Accepts one A sub-chunk (CHUNK_SIZE x PIM_UNIT_CAPACITY) and one B sub-chunk (PIM_UNIT_CAPACITY x CHUNK_SIZE) on a valid pulse.
- Computes the CHUNK_SIZE x CHUNK_SIZE partial product sequentially on a single multiply-accumulate datapath.
- Returns the result with a one-cycle result_valid pulse. The controller accumulates partial products across sub-chunks; this block does not.

---
 rtl/pim_chunk_engine.sv | 113 +++++++++++
 tb/tb_pim_chunk_engine.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pim_chunk_engine.sv
// rtl/pim_chunk_engine.sv - PIM sub-chunk responder: sequential single-MAC partial product of A x B.
module pim_chunk_engine #(
  parameter int WIDTH             = 32,
  parameter int CHUNK_SIZE        = 2,
  parameter int PIM_UNIT_CAPACITY = 2,
  parameter int ID                = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [WIDTH-1:0] matrixA [CHUNK_SIZE][PIM_UNIT_CAPACITY],
  input  logic [WIDTH-1:0] matrixB [PIM_UNIT_CAPACITY][CHUNK_SIZE],
  output logic             ready,
  output logic [WIDTH-1:0] result [CHUNK_SIZE*CHUNK_SIZE],
  output logic             result_valid
);

  localparam int IW = (CHUNK_SIZE > 1) ? $clog2(CHUNK_SIZE) : 1;
  localparam int KW = (PIM_UNIT_CAPACITY > 1) ? $clog2(PIM_UNIT_CAPACITY) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(CHUNK_SIZE - 1);
  localparam logic [KW-1:0] K_LAST = KW'(PIM_UNIT_CAPACITY - 1);

  if (CHUNK_SIZE < 1 || PIM_UNIT_CAPACITY < 1 || ID < 0) begin : g_bad_params
    $error("pim_chunk_engine: illegal parameters");
  end

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t           state;
  logic [IW-1:0]    i, j;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] a_reg [CHUNK_SIZE][PIM_UNIT_CAPACITY];
  logic [WIDTH-1:0] b_reg [PIM_UNIT_CAPACITY][CHUNK_SIZE];
  logic [WIDTH-1:0] acc   [CHUNK_SIZE][CHUNK_SIZE];

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   sum;
  logic               last_iter;

  assign prod      = {{WIDTH{1'b0}}, a_reg[i][k]} * {{WIDTH{1'b0}}, b_reg[k][j]};
  assign sum       = acc[i][j] + prod[WIDTH-1:0];
  assign last_iter = (i == I_LAST) && (j == I_LAST) && (k == K_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ready        <= 1'b1;
      result_valid <= 1'b0;
      i            <= '0;
      j            <= '0;
      k            <= '0;
      for (int r = 0; r < CHUNK_SIZE; r++) begin
        for (int c = 0; c < PIM_UNIT_CAPACITY; c++) begin
          a_reg[r][c] <= '0;
          b_reg[c][r] <= '0;
        end
        for (int c = 0; c < CHUNK_SIZE; c++) begin
          acc[r][c]                <= '0;
          result[r*CHUNK_SIZE + c] <= '0;
        end
      end
    end else begin
      case (state)
        IDLE, DONE: begin
          result_valid <= 1'b0;
          if (valid) begin
            a_reg <= matrixA;
            b_reg <= matrixB;
            for (int r = 0; r < CHUNK_SIZE; r++)
              for (int c = 0; c < CHUNK_SIZE; c++)
                acc[r][c] <= '0;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            ready <= 1'b0;
            state <= COMPUTE;
          end else begin
            ready <= 1'b1;
            state <= IDLE;
          end
        end
        COMPUTE: begin
          acc[i][j] <= sum;
          if (last_iter) begin
            // The final MAC lands directly in result so it is valid during DONE.
            for (int r = 0; r < CHUNK_SIZE; r++)
              for (int c = 0; c < CHUNK_SIZE; c++)
                result[r*CHUNK_SIZE + c] <= (r == int'(i) && c == int'(j)) ? sum : acc[r][c];
            result_valid <= 1'b1;
            ready        <= 1'b1;
            state        <= DONE;
          end else if (k != K_LAST) begin
            k <= k + 1'b1;
          end else begin
            k <= '0;
            if (j != I_LAST) begin
              j <= j + 1'b1;
            end else begin
              j <= '0;
              i <= i + 1'b1;
            end
          end
        end
        default: begin
          ready        <= 1'b1;
          result_valid <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pim_chunk_engine.sv
// tb/tb_pim_chunk_engine.sv - directed self-checking bench for pim_chunk_engine.
module tb_pim_chunk_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [31:0] matrixA [2][2];
  logic [31:0] matrixB [2][2];
  logic        ready;
  logic [31:0] result [4];
  logic        result_valid;

  logic        valid8;
  logic [7:0]  matrixA8 [2][2];
  logic [7:0]  matrixB8 [2][2];
  logic        ready8;
  logic [7:0]  result8 [4];
  logic        result_valid8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pim_chunk_engine #(.WIDTH(32), .CHUNK_SIZE(2), .PIM_UNIT_CAPACITY(2), .ID(0)) dut (
    .clk(clk), .rst(rst), .valid(valid), .matrixA(matrixA), .matrixB(matrixB),
    .ready(ready), .result(result), .result_valid(result_valid)
  );

  pim_chunk_engine #(.WIDTH(8), .CHUNK_SIZE(2), .PIM_UNIT_CAPACITY(2), .ID(1)) dut8 (
    .clk(clk), .rst(rst), .valid(valid8), .matrixA(matrixA8), .matrixB(matrixB8),
    .ready(ready8), .result(result8), .result_valid(result_valid8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [31:0] a00, a01, a10, a11, b00, b01, b10, b11);
    matrixA[0][0] = a00; matrixA[0][1] = a01; matrixA[1][0] = a10; matrixA[1][1] = a11;
    matrixB[0][0] = b00; matrixB[0][1] = b01; matrixB[1][0] = b10; matrixB[1][1] = b11;
  endtask

  // Pulses valid across one rising edge; returns at the negedge of the first COMPUTE cycle.
  task automatic start();
    valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
  endtask

  // Called at the negedge of cycle n0 after acceptance; returns in the result_valid cycle.
  task automatic wait_rv(input string tag, input int n0);
    int n = n0;
    while (!result_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n, 9);
  endtask

  task automatic count_rv(input int cycles, output int cnt);
    cnt = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (result_valid) cnt++;
    end
  endtask

  task automatic chk_result(input string tag, input logic [31:0] r0, r1, r2, r3);
    chk({tag, "_r0"}, result[0], r0);
    chk({tag, "_r1"}, result[1], r1);
    chk({tag, "_r2"}, result[2], r2);
    chk({tag, "_r3"}, result[3], r3);
  endtask

  initial begin
    int cnt;
    rst = 1'b1; valid = 1'b0; valid8 = 1'b0;
    load(0, 0, 0, 0, 0, 0, 0, 0);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        matrixA8[r][c] = 8'd0;
        matrixB8[r][c] = 8'd0;
      end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_ready", ready, 1);
    chk("rst_rv", result_valid, 0);
    chk_result("rst", 0, 0, 0, 0);

    // Test 1: basic product and latency
    load(1, 2, 3, 4, 5, 6, 7, 8);
    start();
    chk("t1_ready_busy", ready, 0);
    chk("t1_rv_busy", result_valid, 0);
    wait_rv("t1_latency", 1);
    chk("t1_ready_done", ready, 1);
    chk_result("t1", 19, 22, 43, 50);
    @(negedge clk);
    chk("t1_rv_one_cycle", result_valid, 0);
    chk("t1_ready_idle", ready, 1);

    // Test 2: 8-bit wrap on the narrow instance
    matrixA8[0][0] = 8'd200;
    matrixB8[0][0] = 8'd2;
    valid8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid8 = 1'b0;
    repeat (10) @(negedge clk);
    chk("t2_r0", 32'(result8[0]), 144);
    chk("t2_r1", 32'(result8[1]), 0);
    chk("t2_r2", 32'(result8[2]), 0);
    chk("t2_r3", 32'(result8[3]), 0);
    chk("t2_ready", 32'(ready8), 1);

    // Test 3: operand capture and valid ignored while busy
    load(1, 2, 3, 4, 1, 0, 0, 1);
    start();
    load(9, 9, 9, 9, 1, 0, 0, 1);
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    wait_rv("t3_latency", 2);
    chk_result("t3", 1, 2, 3, 4);
    count_rv(14, cnt);
    chk("t3_extra_pulses", cnt, 0);

    // Test 4: back-to-back acceptance in DONE
    load(1, 2, 3, 4, 5, 6, 7, 8);
    start();
    wait_rv("t4a_latency", 1);
    chk_result("t4a", 19, 22, 43, 50);
    load(1, 1, 1, 1, 1, 1, 1, 1);
    start();
    chk("t4_ready_busy", ready, 0);
    chk("t4_rv_busy", result_valid, 0);
    chk_result("t4_hold", 19, 22, 43, 50);
    wait_rv("t4b_latency", 1);
    chk_result("t4b", 2, 2, 2, 2);
    @(negedge clk);

    // Test 5: reset mid-operation
    load(1, 2, 3, 4, 5, 6, 7, 8);
    start();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_ready", ready, 1);
    chk_result("t5", 0, 0, 0, 0);
    count_rv(14, cnt);
    chk("t5_no_pulse", cnt, 0);
    start();
    wait_rv("t5_latency", 1);
    chk_result("t5_after", 19, 22, 43, 50);
    @(negedge clk);

    // Test 6: all-zero operands
    load(0, 0, 0, 0, 0, 0, 0, 0);
    start();
    wait_rv("t6_latency", 1);
    chk_result("t6", 0, 0, 0, 0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
